// File: rtl/mem_wb_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage_if
// Description : Bundle between the MEM stage / data memory and the MEM/WB
//               pipeline register, plus the write-back outputs it presents
//               to the register file and forwarding unit.
//   master : drives Stall, Flush, M_* control, M_ALURes, MemDataOut;
//            observes W_Valid, W_RegWr, W_Rd, W_WriteData, W_LoadCount.
//   slave  : the pipeline register itself (mem_wb_stage).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_wb_stage_if #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int CNT_W  = 32
);
  logic              Stall;
  logic              Flush;
  logic              M_Valid;
  logic              M_RegWr;
  logic              M_MemToReg;
  logic [1:0]        M_Digit;
  logic              M_Unsigned;
  logic [RA_W-1:0]   M_Rd;
  logic [DATA_W-1:0] M_ALURes;
  logic [DATA_W-1:0] MemDataOut;
  logic              W_Valid;
  logic              W_RegWr;
  logic [RA_W-1:0]   W_Rd;
  logic [DATA_W-1:0] W_WriteData;
  logic [CNT_W-1:0]  W_LoadCount;

  modport master (
    output Stall, Flush, M_Valid, M_RegWr, M_MemToReg, M_Digit, M_Unsigned,
           M_Rd, M_ALURes, MemDataOut,
    input  W_Valid, W_RegWr, W_Rd, W_WriteData, W_LoadCount
  );

  modport slave (
    input  Stall, Flush, M_Valid, M_RegWr, M_MemToReg, M_Digit, M_Unsigned,
           M_Rd, M_ALURes, MemDataOut,
    output W_Valid, W_RegWr, W_Rd, W_WriteData, W_LoadCount
  );
endinterface
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage
// Description : MEM/WB pipeline register. Captures the MEM-stage control and
//               the data-memory read word, extracts and extends the loaded
//               byte/halfword/word, and presents write-back value, target
//               register and write enable. Keeps a retired-load counter.
// Ports       : CLK   - clock, all state changes on rising edge
//               Reset - synchronous active-high reset
//               bus   - mem_wb_stage_if.slave (MEM inputs, W_* outputs)
//               Interface parameters must match DATA_W/RA_W/CNT_W here.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int CNT_W  = 32
) (
  input  wire             CLK,
  input  wire             Reset,
  mem_wb_stage_if.slave   bus
);

  localparam logic [RA_W-1:0]  c_R0      = '0;
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              r_valid;
  logic              r_regwr;
  logic [RA_W-1:0]   r_rd;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_load_cnt;

  logic [DATA_W-1:0] w_load_data;
  logic [DATA_W-1:0] w_wdata;
  logic              w_ext_bit;
  logic              w_is_load;

  // Memory word is big-endian: the addressed byte sits in the top lane,
  // so narrow loads always come from the most-significant bits.
  always_comb begin
    w_ext_bit   = ~bus.M_Unsigned & bus.MemDataOut[DATA_W-1];
    w_load_data = bus.MemDataOut;
    case (bus.M_Digit)
      2'b00:   w_load_data = {{(DATA_W-8){w_ext_bit}},  bus.MemDataOut[DATA_W-1 -: 8]};
      2'b01:   w_load_data = {{(DATA_W-16){w_ext_bit}}, bus.MemDataOut[DATA_W-1 -: 16]};
      default: w_load_data = bus.MemDataOut;
    endcase
    w_wdata = bus.M_MemToReg ? w_load_data : bus.M_ALURes;
  end

  assign w_is_load = bus.M_Valid & bus.M_MemToReg;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_valid    <= 1'b0;
      r_regwr    <= 1'b0;
      r_rd       <= '0;
      r_wdata    <= '0;
      r_load_cnt <= '0;
    end else if (bus.Flush) begin
      // Bubble: counter keeps its value, nothing is retired.
      r_valid <= 1'b0;
      r_regwr <= 1'b0;
      r_rd    <= '0;
      r_wdata <= '0;
    end else if (!bus.Stall) begin
      r_valid <= bus.M_Valid;
      // r0 is hard-wired zero; never let a write to it reach the regfile.
      r_regwr <= bus.M_RegWr & bus.M_Valid & (bus.M_Rd != c_R0);
      r_rd    <= bus.M_Rd;
      r_wdata <= w_wdata;
      if (w_is_load) begin
        r_load_cnt <= r_load_cnt + c_CNT_ONE;
      end
    end
  end

  assign bus.W_Valid     = r_valid;
  assign bus.W_RegWr     = r_regwr;
  assign bus.W_Rd        = r_rd;
  assign bus.W_WriteData = r_wdata;
  assign bus.W_LoadCount = r_load_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Directed-vector bench for mem_wb_stage. Drives two instances
//               (32-bit and 4-bit load counter) with identical stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

  logic CLK;
  logic Reset;

  mem_wb_stage_if #(.DATA_W(32), .RA_W(5), .CNT_W(32)) ifa ();
  mem_wb_stage_if #(.DATA_W(32), .RA_W(5), .CNT_W(4))  ifb ();

  mem_wb_stage #(.DATA_W(32), .RA_W(5), .CNT_W(32)) dut_a (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (ifa.slave)
  );

  mem_wb_stage #(.DATA_W(32), .RA_W(5), .CNT_W(4)) dut_b (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (ifb.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic        rst, stall, flush, valid, regwr, m2r;
    logic [1:0]  digit;
    logic        uns;
    logic [4:0]  rd;
    logic [31:0] alu, mem;
    logic        ev, erw;
    logic [4:0]  erd;
    logic [31:0] ewd;
    logic [31:0] ecnt;
  } vec_t;

  vec_t tv[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(logic rst, logic stall, logic flush, logic valid,
                              logic regwr, logic m2r, logic [1:0] digit, logic uns,
                              logic [4:0] rd, logic [31:0] alu, logic [31:0] mem,
                              logic ev, logic erw, logic [4:0] erd,
                              logic [31:0] ewd, logic [31:0] ecnt);
    vec_t v;
    v.rst = rst; v.stall = stall; v.flush = flush; v.valid = valid;
    v.regwr = regwr; v.m2r = m2r; v.digit = digit; v.uns = uns;
    v.rd = rd; v.alu = alu; v.mem = mem;
    v.ev = ev; v.erw = erw; v.erd = erd; v.ewd = ewd; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(vec_t v);
    Reset          = v.rst;
    ifa.Stall      = v.stall;  ifb.Stall      = v.stall;
    ifa.Flush      = v.flush;  ifb.Flush      = v.flush;
    ifa.M_Valid    = v.valid;  ifb.M_Valid    = v.valid;
    ifa.M_RegWr    = v.regwr;  ifb.M_RegWr    = v.regwr;
    ifa.M_MemToReg = v.m2r;    ifb.M_MemToReg = v.m2r;
    ifa.M_Digit    = v.digit;  ifb.M_Digit    = v.digit;
    ifa.M_Unsigned = v.uns;    ifb.M_Unsigned = v.uns;
    ifa.M_Rd       = v.rd;     ifb.M_Rd       = v.rd;
    ifa.M_ALURes   = v.alu;    ifb.M_ALURes   = v.alu;
    ifa.MemDataOut = v.mem;    ifb.MemDataOut = v.mem;
  endtask

  task automatic check_all(string tag, vec_t v);
    logic [31:0] cnt4;
    cnt4 = {28'd0, v.ecnt[3:0]};
    chk({tag, ".W_Valid"},     {31'd0, ifa.W_Valid},     {31'd0, v.ev});
    chk({tag, ".W_RegWr"},     {31'd0, ifa.W_RegWr},     {31'd0, v.erw});
    chk({tag, ".W_Rd"},        {27'd0, ifa.W_Rd},        {27'd0, v.erd});
    chk({tag, ".W_WriteData"}, ifa.W_WriteData,          v.ewd);
    chk({tag, ".W_LoadCount"}, ifa.W_LoadCount,          v.ecnt);
    chk({tag, ".W_LoadCount4"},{28'd0, ifb.W_LoadCount}, cnt4);
  endtask

  initial begin
    vec_t v;
    //              rst st fl va rw m2 dg    un rd     alu           mem            ev rw erd    ewd           cnt
    tv.push_back(mk(1, 0, 0, 1, 1, 1, 2'b10, 0, 5'd7,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 5'd0,  32'h0000_0000, 0)); // reset
    tv.push_back(mk(1, 1, 0, 1, 1, 1, 2'b00, 1, 5'd9,  32'h5555_AAAA, 32'hC3C3_C3C3, 0, 0, 5'd0,  32'h0000_0000, 0)); // reset held
    tv.push_back(mk(0, 0, 0, 1, 1, 0, 2'b00, 0, 5'd5,  32'h1234_5678, 32'hDEAD_0000, 1, 1, 5'd5,  32'h1234_5678, 0)); // ALU op
    tv.push_back(mk(0, 0, 0, 1, 1, 1, 2'b00, 0, 5'd1,  32'h0000_0100, 32'h80F1_2233, 1, 1, 5'd1,  32'hFFFF_FF80, 1)); // lb
    tv.push_back(mk(0, 0, 0, 1, 1, 1, 2'b00, 1, 5'd2,  32'h0000_0100, 32'h80F1_2233, 1, 1, 5'd2,  32'h0000_0080, 2)); // lbu
    tv.push_back(mk(0, 0, 0, 1, 1, 1, 2'b01, 0, 5'd3,  32'h0000_0100, 32'h80F1_2233, 1, 1, 5'd3,  32'hFFFF_80F1, 3)); // lh
    tv.push_back(mk(0, 0, 0, 1, 1, 1, 2'b01, 1, 5'd4,  32'h0000_0100, 32'h80F1_2233, 1, 1, 5'd4,  32'h0000_80F1, 4)); // lhu
    tv.push_back(mk(0, 0, 0, 1, 1, 1, 2'b10, 0, 5'd5,  32'h0000_0100, 32'h80F1_2233, 1, 1, 5'd5,  32'h80F1_2233, 5)); // lw
    tv.push_back(mk(0, 0, 0, 1, 1, 1, 2'b11, 1, 5'd6,  32'h0000_0100, 32'h80F1_2233, 1, 1, 5'd6,  32'h80F1_2233, 6)); // digit 11
    tv.push_back(mk(0, 0, 0, 1, 1, 1, 2'b00, 0, 5'd9,  32'h0000_0104, 32'h7F00_0000, 1, 1, 5'd9,  32'h0000_007F, 7)); // lb positive
    tv.push_back(mk(0, 0, 0, 1, 1, 1, 2'b10, 0, 5'd0,  32'h0000_0108, 32'h0BAD_F00D, 1, 0, 5'd0,  32'h0BAD_F00D, 8)); // load to r0
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 2'b10, 0, 5'd3,  32'h0000_010C, 32'h1111_2222, 0, 0, 5'd3,  32'h1111_2222, 8)); // bubble
    tv.push_back(mk(0, 0, 0, 1, 1, 0, 2'b00, 0, 5'd4,  32'h0000_000A, 32'hFFFF_FFFF, 1, 1, 5'd4,  32'h0000_000A, 8)); // capture 0xA
    tv.push_back(mk(0, 1, 0, 1, 1, 1, 2'b10, 0, 5'd8,  32'h0000_0BBB, 32'h1234_5678, 1, 1, 5'd4,  32'h0000_000A, 8)); // stall 1
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 2'b01, 1, 5'd0,  32'h0000_0CCC, 32'h8765_4321, 1, 1, 5'd4,  32'h0000_000A, 8)); // stall 2
    tv.push_back(mk(0, 1, 0, 1, 1, 1, 2'b00, 0, 5'd31, 32'h0000_0DDD, 32'hFFFF_0000, 1, 1, 5'd4,  32'h0000_000A, 8)); // stall 3
    tv.push_back(mk(0, 1, 1, 1, 1, 1, 2'b10, 0, 5'd12, 32'h0000_0EEE, 32'h5A5A_5A5A, 0, 0, 5'd0,  32'h0000_0000, 8)); // stall+flush
    tv.push_back(mk(0, 0, 1, 1, 1, 1, 2'b10, 0, 5'd13, 32'h0000_0FFF, 32'hA5A5_A5A5, 0, 0, 5'd0,  32'h0000_0000, 8)); // flush
    tv.push_back(mk(0, 0, 0, 1, 1, 0, 2'b00, 0, 5'd31, 32'hDEAD_BEEF, 32'h0000_0000, 1, 1, 5'd31, 32'hDEAD_BEEF, 8)); // capture
    tv.push_back(mk(1, 1, 0, 1, 1, 1, 2'b10, 0, 5'd14, 32'h1111_1111, 32'h2222_2222, 0, 0, 5'd0,  32'h0000_0000, 0)); // reset+stall

    foreach (tv[i]) begin
      drive(tv[i]);
      @(posedge CLK);
      @(negedge CLK);
      check_all($sformatf("vec%0d", i), tv[i]);
    end

    // 17 consecutive loads from zero: 4-bit counter wraps to 1.
    for (int k = 1; k <= 17; k++) begin
      v = mk(0, 0, 0, 1, 1, 1, 2'b10, 0, 5'(k), 32'h200 + 32'(k), 32'h0100_0000 * 32'(k),
             1, 1, 5'(k), 32'h0100_0000 * 32'(k), 32'(k));
      drive(v);
      @(posedge CLK);
      @(negedge CLK);
      chk($sformatf("wrap%0d.cnt32", k), ifa.W_LoadCount, 32'(k));
      chk($sformatf("wrap%0d.cnt4", k), {28'd0, ifb.W_LoadCount}, 32'(k % 16));
    end
    chk("wrap.final4", {28'd0, ifb.W_LoadCount}, 32'd1);

    // Load presented under stall must not count nor change data.
    v = mk(0, 1, 0, 1, 1, 1, 2'b00, 0, 5'd20, 32'h300, 32'hFF00_0000,
           1, 1, 5'd17, 32'h1100_0000, 32'd17);
    drive(v);
    @(posedge CLK);
    @(negedge CLK);
    check_all("stall_load", v);

    // Random inputs under reset, then the first capture on the following edge.
    v = mk(1, 1'($urandom), 1'($urandom), 1, 1, 1'($urandom), 2'($urandom), 1'($urandom),
           5'($urandom), $urandom, $urandom, 0, 0, 5'd0, 32'h0, 32'h0);
    drive(v);
    @(posedge CLK);
    @(negedge CLK);
    check_all("rst_rand", v);
    v = mk(0, 0, 0, 1, 1, 0, 2'b00, 0, 5'd5, 32'h1234_5678, 32'h0,
           1, 1, 5'd5, 32'h1234_5678, 32'h0);
    drive(v);
    @(posedge CLK);
    @(negedge CLK);
    check_all("post_rst", v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
MEM/WB pipeline register of the five-stage CPU. It sits directly downstream of the data memory. On each rising edge it captures the memory read word and the MEM-stage control. For loads, it extracts and extends the addressed byte, halfword or word. It presents the write-back value, destination register and write enable to the register file and the forwarding unit. It also keeps a retired-load counter for debug.

Parameters:
DATA_W, 32, datapath and memory word width
RA_W, 5, register-file address width
CNT_W, 32, width of retired-load counter

Ports:
CLK  in  1  clock; all state updates on rising edge
Reset  in  1  synchronous, active-high reset
Stall  in  1  hold all registered state this cycle
Flush  in  1  load a bubble this cycle
M_Valid  in  1  MEM-stage instruction valid
M_RegWr  in  1  MEM-stage register write enable
M_MemToReg  in  1  1 = load (write-back memory data), 0 = write-back ALU result
M_Digit  in  2  access size: 00 8-bit, 01 16-bit, 10 32-bit, 11 treated as 32-bit
M_Unsigned  in  1  1 = zero-extend, 0 = sign-extend (8/16-bit loads only)
M_Rd  in  RA_W  destination register
M_ALURes  in  DATA_W  ALU result / memory address
MemDataOut  in  DATA_W  data memory read word; big-endian, byte at DAddr in [31:24]; stable at rising edge
W_Valid  out  1  WB-stage instruction valid
W_RegWr  out  1  register-file write enable
W_Rd  out  RA_W  register-file write address
W_WriteData  out  DATA_W  register-file write data
W_LoadCount  out  CNT_W  number of loads captured into WB

Behaviour:
- All outputs are registered. There is no combinational path from any input to any output.
- Latency is one cycle: MEM-stage values presented before rising edge N appear on W_* after edge N.
- Priority at each rising edge is Reset > Flush > Stall > capture.
- Reset: W_Valid=0, W_RegWr=0, W_Rd=0, W_WriteData=0, W_LoadCount=0.
- Flush: W_Valid=0 and W_RegWr=0. W_Rd and W_WriteData are cleared to 0. W_LoadCount is held.
- Flush and Stall asserted together: Flush wins.
- Stall (no Flush): every output register holds its value, including W_LoadCount. Inputs are ignored.
- Capture:
  - W_Valid <= M_Valid.
  - W_RegWr <= M_RegWr & M_Valid & (M_Rd != 0); writes to r0 are suppressed.
  - W_Rd <= M_Rd.
- Write data selection:
  - M_MemToReg=0: W_WriteData <= M_ALURes.
  - M_MemToReg=1 and M_Digit=00: byte = MemDataOut[31:24]; extended to DATA_W by M_Unsigned (zero) or bit 31 (sign).
  - M_MemToReg=1 and M_Digit=01: half = MemDataOut[31:16]; extended likewise using bit 31.
  - M_MemToReg=1 and M_Digit=10 or 11: full MemDataOut; M_Unsigned is ignored.
- Load counter: increments by 1 on a capture edge when M_Valid & M_MemToReg. It wraps from all-ones to 0 with no saturation or flag.
- Invalid instructions (M_Valid=0) are captured as bubbles: W_RegWr=0. W_WriteData still follows the selection rules and is don't-care to consumers.
- Reset mid-stall or mid-flush: Reset dominates in the same edge.
- Reset deasserted: the first capture happens on the following edge.
- Alignment is not checked here; the memory already returns the 4 bytes starting at the address.

Test Plan:
- Reset: hold Reset 2 cycles with random inputs -> all W_* = 0, W_LoadCount=0. After release, ALU op (M_Valid=1, M_RegWr=1, M_MemToReg=0, M_Rd=5, M_ALURes=0x1234_5678) -> next cycle W_RegWr=1, W_Rd=5, W_WriteData=0x1234_5678.
- Load extension, MemDataOut=0x80F1_2233:
  - byte signed -> 0xFFFF_FF80
  - byte unsigned -> 0x0000_0080
  - half signed -> 0xFFFF_80F1
  - half unsigned -> 0x0000_80F1
  - word -> 0x80F1_2233
  - Digit=11 -> 0x80F1_2233
  - W_LoadCount = 6 after the six loads.
- r0 suppression: valid load, M_RegWr=1, M_Rd=0 -> W_RegWr=0, W_LoadCount still increments.
- Stall/Flush:
  - Capture ALU value 0xA, then Stall 3 cycles with changing inputs -> W_WriteData stays 0xA.
  - Assert Stall and Flush together -> W_Valid=0, W_RegWr=0, W_WriteData=0, W_LoadCount unchanged.
- Counter wrap: CNT_W=4, 17 consecutive valid loads -> W_LoadCount reads 1. One load under Stall -> no increment.
- Reset during Stall: Stall=1, Reset=1 on the same edge -> all outputs 0.
